// File: rtl/mux_scan_if.sv
// Bus bundle for mux_scan: control/data inputs from the producer and the
// tagged, registered selection back to the consumer.
interface mux_scan_if #(
  parameter int WIDTH  = 4,
  parameter int CANAIS = 4,
  parameter int SEL_W  = 2
);
  logic                      habilita;
  logic                      modo;
  logic [SEL_W-1:0]          seletor;
  logic [CANAIS*WIDTH-1:0]   entradas;
  logic [WIDTH-1:0]          out;
  logic [SEL_W-1:0]          canal;
  logic                      valido;

  modport master (
    output habilita, modo, seletor, entradas,
    input  out, canal, valido
  );

  modport slave (
    input  habilita, modo, seletor, entradas,
    output out, canal, valido
  );
endinterface

// File: rtl/mux_scan.sv
// Registered N-channel multiplexer with direct select and round-robin scan.
// Optional macro MUX_SEL_FILTER_EN adds a 2-sample selector filter in direct mode.
module mux_scan #(
  parameter int WIDTH    = 4,
  parameter int CANAIS   = 4,
  parameter int SEL_W    = 2,
  parameter int SCAN_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  mux_scan_if.slave   bus
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {OCIOSO, DIRETO, VARRE} state_t;

  state_t            state_reg;
  logic [SEL_W-1:0]  ptr_reg;
  logic [DIV_W-1:0]  div_reg;
  logic [WIDTH-1:0]  out_reg;
  logic [SEL_W-1:0]  canal_reg;
  logic              valido_reg;

  logic [WIDTH-1:0]  chan [CANAIS];
  logic [SEL_W-1:0]  dsel;
  logic [WIDTH-1:0]  dsel_data;
  logic              dsel_ok;
  logic [WIDTH-1:0]  scan_data;
  logic [SEL_W-1:0]  ptr_next;
  logic              div_last;

  genvar gi;
  generate
    for (gi = 0; gi < CANAIS; gi++) begin : g_chan
      assign chan[gi] = bus.entradas[gi*WIDTH +: WIDTH];
    end
  endgenerate

`ifdef MUX_SEL_FILTER_EN
  logic [SEL_W-1:0]  sel_acc_reg;
  logic [SEL_W-1:0]  sel_prev_reg;

  // Entry into DIRETO accepts the current selector at once; afterwards a
  // change must be seen on two consecutive enabled edges.
  always_comb begin
    dsel = sel_acc_reg;
    if (state_reg != DIRETO || bus.seletor == sel_prev_reg)
      dsel = bus.seletor;
  end
`else
  assign dsel = bus.seletor;
`endif

  // Explicit compare loop keeps out-of-range selectors from reading past the array.
  always_comb begin
    dsel_data = '0;
    dsel_ok   = 1'b0;
    scan_data = '0;
    for (int k = 0; k < CANAIS; k++) begin
      if (dsel == SEL_W'(k)) begin
        dsel_data = chan[k];
        dsel_ok   = 1'b1;
      end
      if (ptr_reg == SEL_W'(k))
        scan_data = chan[k];
    end
  end

  assign ptr_next = (ptr_reg == SEL_W'(CANAIS - 1)) ? '0 : ptr_reg + 1'b1;
  assign div_last = (div_reg == DIV_W'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= OCIOSO;
      ptr_reg      <= '0;
      div_reg      <= '0;
      out_reg      <= '0;
      canal_reg    <= '0;
      valido_reg   <= 1'b0;
`ifdef MUX_SEL_FILTER_EN
      sel_acc_reg  <= '0;
      sel_prev_reg <= '0;
`endif
    end else if (!bus.habilita) begin
      // Pause: scan position is kept so VARRE can resume where it stopped.
      state_reg  <= OCIOSO;
      valido_reg <= 1'b0;
    end else if (!bus.modo) begin
      state_reg  <= DIRETO;
      out_reg    <= dsel_data;
      canal_reg  <= dsel;
      valido_reg <= dsel_ok;
      // Passing through DIRETO forces the next scan to restart at channel 0.
      if (state_reg != DIRETO) begin
        ptr_reg <= '0;
        div_reg <= '0;
      end
`ifdef MUX_SEL_FILTER_EN
      sel_acc_reg  <= dsel;
      sel_prev_reg <= bus.seletor;
`endif
    end else begin
      state_reg  <= VARRE;
      out_reg    <= scan_data;
      canal_reg  <= ptr_reg;
      valido_reg <= (div_reg == '0);
      if (div_last) begin
        div_reg <= '0;
        ptr_reg <= ptr_next;
      end else begin
        div_reg <= div_reg + 1'b1;
      end
    end
  end

  assign bus.out    = out_reg;
  assign bus.canal  = canal_reg;
  assign bus.valido = valido_reg;

endmodule
